// File: rtl/calc_sched_pkg.sv
// Shared widths, encodings and request payload for the calc request scheduler.
package calc_sched_pkg;

  localparam int unsigned NPORTS     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CMD_W      = 4;
  localparam int unsigned TAG_W      = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PORT_W     = 2;
  localparam int unsigned RESP_W     = 2;
  localparam int unsigned PTR_W      = TAG_W;
  localparam int unsigned CNT_W      = PTR_W + 1;

  localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_SHL = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_SHR = CMD_W'(6);

  localparam logic [RESP_W-1:0] RESP_NONE = RESP_W'(0);
  localparam logic [RESP_W-1:0] RESP_OK   = RESP_W'(1);
  localparam logic [RESP_W-1:0] RESP_ERR  = RESP_W'(2);

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } calc_req_t;

  // Round-robin successor of a port index (wraps naturally at NPORTS=4).
  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return PORT_W'(p + PORT_W'(1));
  endfunction

endpackage

// File: rtl/calc_req_fifo.sv
// Per-port request queue; exposes the head and the entry behind it so the
// arbiter can look past an entry that is being popped this cycle.
module calc_req_fifo
  import calc_sched_pkg::*;
(
  input  logic             c_clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  calc_req_t        i_data,
  output calc_req_t        o_head_c,
  output calc_req_t        o_next_c,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [CNT_W-1:0] o_count
);

  calc_req_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_next_c  = r_mem[PTR_W'(r_rd_ptr + 1'b1)];
  assign o_full_c  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge c_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (i_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({i_push, i_pop})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/calc_req_scheduler.sv
// Shares one ALU among NPORTS requesters: captures two-cycle requests,
// queues them per port, issues round-robin and routes tagged results back.
module calc_req_scheduler
  import calc_sched_pkg::*;
(
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic [NPORTS*CMD_W-1:0]    req_cmd_in,
  input  logic [NPORTS*DATA_W-1:0]   req_data_in,
  input  logic [NPORTS*TAG_W-1:0]    req_tag_in,
  output logic                       alu_valid,
  input  logic                       alu_ready,
  output logic [CMD_W-1:0]           alu_cmd,
  output logic [DATA_W-1:0]          alu_op1,
  output logic [DATA_W-1:0]          alu_op2,
  output logic [PORT_W-1:0]          alu_port,
  output logic [TAG_W-1:0]           alu_tag,
  input  logic                       res_valid,
  input  logic [PORT_W-1:0]          res_port,
  input  logic [TAG_W-1:0]           res_tag,
  input  logic [DATA_W-1:0]          res_data,
  input  logic [RESP_W-1:0]          res_resp,
  output logic [NPORTS*DATA_W-1:0]   out_data,
  output logic [NPORTS*RESP_W-1:0]   out_resp,
  output logic [NPORTS*TAG_W-1:0]    out_tag,
  output logic [NPORTS-1:0]          err_overflow,
  output logic                       err_spurious
);

  logic [CMD_W-1:0]  w_cmd_in  [NPORTS];
  logic [DATA_W-1:0] w_data_in [NPORTS];
  logic [TAG_W-1:0]  w_tag_in  [NPORTS];

  cap_state_e        r_cap_state [NPORTS];
  logic [CMD_W-1:0]  r_cap_cmd   [NPORTS];
  logic [TAG_W-1:0]  r_cap_tag   [NPORTS];
  logic [DATA_W-1:0] r_cap_op1   [NPORTS];

  calc_req_t         w_cap_req [NPORTS];
  calc_req_t         w_head    [NPORTS];
  calc_req_t         w_next    [NPORTS];
  calc_req_t         w_cand    [NPORTS];
  logic [CNT_W-1:0]  w_count   [NPORTS];
  logic [NPORTS-1:0] w_push_req, w_push, w_pop, w_ovf;
  logic [NPORTS-1:0] w_full, w_empty, w_avail, w_res_ok;

  logic              w_hs, w_load, w_grant_valid;
  logic [PORT_W-1:0] w_start, w_grant_port;
  calc_req_t         w_grant_req;

  logic              r_alu_valid;
  logic [CMD_W-1:0]  r_alu_cmd;
  logic [DATA_W-1:0] r_alu_op1, r_alu_op2;
  logic [PORT_W-1:0] r_alu_port;
  logic [TAG_W-1:0]  r_alu_tag;
  logic [PORT_W-1:0] r_rr_ptr;

  logic [CNT_W-1:0]          r_outst [NPORTS];
  logic [NPORTS*DATA_W-1:0]  r_out_data;
  logic [NPORTS*RESP_W-1:0]  r_out_resp;
  logic [NPORTS*TAG_W-1:0]   r_out_tag;
  logic [NPORTS-1:0]         r_err_overflow;
  logic                      r_err_spurious;

  assign w_hs = r_alu_valid & alu_ready;

  // Per-port input slicing, push/pop qualification and result acceptance.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      w_cmd_in[p]   = req_cmd_in[p*CMD_W +: CMD_W];
      w_data_in[p]  = req_data_in[p*DATA_W +: DATA_W];
      w_tag_in[p]   = req_tag_in[p*TAG_W +: TAG_W];
      w_push_req[p] = (r_cap_state[p] == CAP_OP2);
      w_cap_req[p]  = '{cmd: r_cap_cmd[p], tag: r_cap_tag[p],
                        op1: r_cap_op1[p], op2: w_data_in[p]};
      w_pop[p]      = w_hs && (r_alu_port == PORT_W'(p));
      // A full queue still accepts a push when its head leaves this cycle.
      w_push[p]     = w_push_req[p] && (!w_full[p] || w_pop[p]);
      w_ovf[p]      = w_push_req[p] && w_full[p] && !w_pop[p];
      w_res_ok[p]   = res_valid && (res_port == PORT_W'(p)) && (r_outst[p] != '0);
    end
  end

  // Per-port request queues.
  for (genvar g = 0; g < NPORTS; g++) begin : g_fifo
    calc_req_fifo u_fifo (
      .c_clk     (c_clk),
      .reset     (reset),
      .i_push    (w_push[g]),
      .i_pop     (w_pop[g]),
      .i_data    (w_cap_req[g]),
      .o_head_c  (w_head[g]),
      .o_next_c  (w_next[g]),
      .o_full_c  (w_full[g]),
      .o_empty_c (w_empty[g]),
      .o_count   (w_count[g])
    );
  end

  // Round-robin pick over queue contents as they will stand after this
  // cycle's pop, including a request being pushed into an empty queue.
  always_comb begin
    w_load        = !r_alu_valid || alu_ready;
    w_start       = w_hs ? next_port(r_alu_port) : r_rr_ptr;
    w_grant_valid = 1'b0;
    w_grant_port  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_pop[p]) begin
        w_avail[p] = (w_count[p] >= CNT_W'(2)) || w_push[p];
        w_cand[p]  = (w_count[p] >= CNT_W'(2)) ? w_next[p] : w_cap_req[p];
      end else begin
        w_avail[p] = !w_empty[p] || w_push[p];
        w_cand[p]  = w_empty[p] ? w_cap_req[p] : w_head[p];
      end
    end
    for (int i = 0; i < NPORTS; i++) begin
      if (!w_grant_valid && w_avail[PORT_W'(w_start + PORT_W'(i))]) begin
        w_grant_valid = 1'b1;
        w_grant_port  = PORT_W'(w_start + PORT_W'(i));
      end
    end
    w_grant_req = w_cand[w_grant_port];
  end

  // Capture FSM per port: cmd cycle latches cmd/tag/op1, next cycle pushes.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        r_cap_state[p] <= CAP_IDLE;
        r_cap_cmd[p]   <= '0;
        r_cap_tag[p]   <= '0;
        r_cap_op1[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (r_cap_state[p] == CAP_IDLE) begin
          if (w_cmd_in[p] != '0) begin
            r_cap_cmd[p]   <= w_cmd_in[p];
            r_cap_tag[p]   <= w_tag_in[p];
            r_cap_op1[p]   <= w_data_in[p];
            r_cap_state[p] <= CAP_OP2;
          end
        end else begin
          r_cap_state[p] <= CAP_IDLE;
        end
      end
    end
  end

  // Issue register: holds until handshake, then loads the next winner.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_alu_valid <= 1'b0;
      r_alu_cmd   <= '0;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_alu_port  <= '0;
      r_alu_tag   <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load) begin
        r_alu_valid <= w_grant_valid;
        r_alu_cmd   <= w_grant_valid ? w_grant_req.cmd : '0;
        r_alu_op1   <= w_grant_valid ? w_grant_req.op1 : '0;
        r_alu_op2   <= w_grant_valid ? w_grant_req.op2 : '0;
        r_alu_port  <= w_grant_valid ? w_grant_port    : '0;
        r_alu_tag   <= w_grant_valid ? w_grant_req.tag : '0;
      end
      if (w_hs) r_rr_ptr <= next_port(r_alu_port);
    end
  end

  // Outstanding request counters and sticky error flags.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NPORTS; p++) r_outst[p] <= '0;
      r_err_overflow <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        case ({w_push[p], w_res_ok[p]})
          2'b10: if (r_outst[p] != CNT_W'(FIFO_DEPTH)) r_outst[p] <= CNT_W'(r_outst[p] + 1'b1);
          2'b01: r_outst[p] <= CNT_W'(r_outst[p] - 1'b1);
          default: r_outst[p] <= r_outst[p];
        endcase
      end
      r_err_overflow <= r_err_overflow | w_ovf;
      if (res_valid && (r_outst[res_port] == '0)) r_err_spurious <= 1'b1;
    end
  end

  // Result routing: one-cycle pulse on the destination port, zero elsewhere.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_out_data <= '0;
      r_out_resp <= '0;
      r_out_tag  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        r_out_data[p*DATA_W +: DATA_W] <= w_res_ok[p] ? res_data : '0;
        r_out_resp[p*RESP_W +: RESP_W] <= w_res_ok[p] ? res_resp : '0;
        r_out_tag[p*TAG_W +: TAG_W]    <= w_res_ok[p] ? res_tag  : '0;
      end
    end
  end

  assign alu_valid    = r_alu_valid;
  assign alu_cmd      = r_alu_cmd;
  assign alu_op1      = r_alu_op1;
  assign alu_op2      = r_alu_op2;
  assign alu_port     = r_alu_port;
  assign alu_tag      = r_alu_tag;
  assign out_data     = r_out_data;
  assign out_resp     = r_out_resp;
  assign out_tag      = r_out_tag;
  assign err_overflow = r_err_overflow;
  assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed bench for calc_req_scheduler: table of single round trips plus
// hand-written multi-cycle sequences.
module tb_calc_req_scheduler;
  import calc_sched_pkg::*;

  logic         c_clk;
  logic         reset;
  logic [15:0]  req_cmd_in;
  logic [127:0] req_data_in;
  logic [7:0]   req_tag_in;
  logic         alu_valid;
  logic         alu_ready;
  logic [3:0]   alu_cmd;
  logic [31:0]  alu_op1;
  logic [31:0]  alu_op2;
  logic [1:0]   alu_port;
  logic [1:0]   alu_tag;
  logic         res_valid;
  logic [1:0]   res_port;
  logic [1:0]   res_tag;
  logic [31:0]  res_data;
  logic [1:0]   res_resp;
  logic [127:0] out_data;
  logic [7:0]   out_resp;
  logic [7:0]   out_tag;
  logic [3:0]   err_overflow;
  logic         err_spurious;

  calc_req_scheduler dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_port(alu_port), .alu_tag(alu_tag),
    .res_valid(res_valid), .res_port(res_port), .res_tag(res_tag),
    .res_data(res_data), .res_resp(res_resp),
    .out_data(out_data), .out_resp(out_resp), .out_tag(out_tag),
    .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_res;
    logic [1:0]  exp_resp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    res_valid = 1'b0; res_port = '0; res_tag = '0; res_data = '0; res_resp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drive_req(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                           input logic [31:0] data);
    req_cmd_in[p*4 +: 4]   = cmd;
    req_tag_in[p*2 +: 2]   = tag;
    req_data_in[p*32 +: 32] = data;
  endtask

  task automatic drive_res(input int p, input logic [1:0] tag, input logic [31:0] data,
                           input logic [1:0] resp);
    res_valid = 1'b1; res_port = 2'(p); res_tag = tag; res_data = data; res_resp = resp;
  endtask

  function automatic logic [31:0] od(input int p);
    return out_data[p*32 +: 32];
  endfunction
  function automatic logic [1:0] orsp(input int p);
    return out_resp[p*2 +: 2];
  endfunction
  function automatic logic [1:0] otag(input int p);
    return out_tag[p*2 +: 2];
  endfunction

  vec_t tbl [5];
  vec_t v;
  logic [7:0] others;
  int order [4];

  initial begin
    tbl[0] = '{0, CMD_ADD, 2'd2, 32'd5,   32'd7, 32'd12, RESP_OK};
    tbl[1] = '{1, CMD_SUB, 2'd1, 32'd20,  32'd8, 32'd12, RESP_OK};
    tbl[2] = '{2, CMD_SHL, 2'd3, 32'd1,   32'd4, 32'd16, RESP_OK};
    tbl[3] = '{3, CMD_SHR, 2'd0, 32'd256, 32'd4, 32'd16, RESP_OK};
    tbl[4] = '{1, 4'hF,    2'd0, 32'd3,   32'd3, 32'd0,  RESP_ERR};

    reset = 1'b0;
    alu_ready = 1'b1;
    clear_inputs();
    tick();
    // Reset state
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_alu_fields", {alu_cmd, alu_op1, alu_op2, alu_port, alu_tag}, 0);
    chk("rst_out_data", |out_data, 0);
    chk("rst_out_resp_tag", {out_resp, out_tag}, 0);
    chk("rst_errs", {err_overflow, err_spurious}, 0);
    reset = 1'b1;
    tick();

    // Table: single request round trips
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      drive_req(v.port, v.cmd, v.tag, v.op1);
      tick();
      chk($sformatf("row%0d_not_early", i), alu_valid, 0);
      drive_req(v.port, 4'd0, 2'd0, v.op2);
      tick();
      drive_req(v.port, 4'd0, 2'd0, 32'd0);
      chk($sformatf("row%0d_valid", i), alu_valid, 1);
      chk($sformatf("row%0d_cmd_port_tag", i), {alu_cmd, alu_port, alu_tag},
          {v.cmd, 2'(v.port), v.tag});
      chk($sformatf("row%0d_ops", i), {alu_op1, alu_op2}, {v.op1, v.op2});
      tick();
      chk($sformatf("row%0d_valid_drop", i), alu_valid, 0);
      drive_res(v.port, v.tag, v.exp_res, v.exp_resp);
      tick();
      res_valid = 1'b0;
      chk($sformatf("row%0d_out_data", i), od(v.port), v.exp_res);
      chk($sformatf("row%0d_out_resp_tag", i), {orsp(v.port), otag(v.port)}, {v.exp_resp, v.tag});
      others = out_resp;
      others[v.port*2 +: 2] = 2'b00;
      chk($sformatf("row%0d_others_zero", i), others, 0);
      tick();
      chk($sformatf("row%0d_one_cycle", i), {od(v.port), orsp(v.port)}, 0);
    end
    chk("table_errs", {err_overflow, err_spurious}, 0);

    // All four ports at once, round-robin from 0 then from 1
    do_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        drive_req(0, CMD_ADD, 2'd0, 32'd1);
        tick();
        drive_req(0, 4'd0, 2'd0, 32'd1);
        tick();
        drive_req(0, 4'd0, 2'd0, 32'd0);
        chk("rr_prep_port0", {alu_valid, alu_port}, {1'b1, 2'd0});
        tick();
      end
      for (int p = 0; p < 4; p++) drive_req(p, CMD_ADD, 2'(p), 32'(100 + p));
      tick();
      for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 2'd0, 32'(200 + p));
      tick();
      for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 2'd0, 32'd0);
      for (int k = 0; k < 4; k++) order[k] = (k + r) % 4;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rr%0d_k%0d_valid_port", r, k), {alu_valid, alu_port}, {1'b1, 2'(order[k])});
        chk($sformatf("rr%0d_k%0d_ops", r, k), {alu_op1, alu_op2},
            {32'(100 + order[k]), 32'(200 + order[k])});
        tick();
      end
      chk($sformatf("rr%0d_idle", r), alu_valid, 0);
    end

    // Backpressure: fields stable for 5 cycles, single pop on ready
    do_reset();
    alu_ready = 1'b0;
    drive_req(2, CMD_SUB, 2'd1, 32'd50);
    tick();
    drive_req(2, 4'd0, 2'd0, 32'd9);
    tick();
    drive_req(2, 4'd0, 2'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_k%0d_ctl", k), {alu_valid, alu_cmd, alu_port, alu_tag},
          {1'b1, CMD_SUB, 2'd2, 2'd1});
      chk($sformatf("bp_k%0d_ops", k), {alu_op1, alu_op2}, {32'd50, 32'd9});
      tick();
    end
    alu_ready = 1'b1;
    tick();
    chk("bp_popped", alu_valid, 0);
    tick();
    chk("bp_no_reissue", alu_valid, 0);

    // Overflow on port3, then drain and return results
    do_reset();
    alu_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      drive_req(3, CMD_ADD, 2'(r), 32'(r + 1));
      tick();
      drive_req(3, 4'd0, 2'd0, 32'd10);
      tick();
      chk($sformatf("ovf_r%0d", r), err_overflow, (r == 4) ? 4'b1000 : 4'b0000);
    end
    drive_req(3, 4'd0, 2'd0, 32'd0);
    alu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_issue%0d", k), {alu_valid, alu_port, alu_tag, alu_op1},
          {1'b1, 2'd3, 2'(k), 32'(k + 1)});
      tick();
    end
    chk("ovf_fifth_dropped", alu_valid, 0);
    for (int k = 0; k < 4; k++) begin
      drive_res(3, 2'(k), 32'(k + 11), RESP_OK);
      tick();
      chk($sformatf("ovf_res%0d", k), {od(3), orsp(3), otag(3), err_spurious},
          {32'(k + 11), RESP_OK, 2'(k), 1'b0});
    end
    drive_res(3, 2'd0, 32'd77, RESP_OK);
    tick();
    res_valid = 1'b0;
    chk("ovf_counter_zero", {orsp(3), err_spurious}, {RESP_NONE, 1'b1});

    // Spurious result on port1
    do_reset();
    chk("spur_before", err_spurious, 0);
    drive_res(1, 2'd2, 32'd99, RESP_OK);
    tick();
    res_valid = 1'b0;
    chk("spur_out_zero", {od(1), orsp(1)}, 0);
    chk("spur_flag", err_spurious, 1);

    // Asynchronous reset mid-operation
    do_reset();
    alu_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drive_req(1, CMD_ADD, 2'(r), 32'd5);
      tick();
      drive_req(1, 4'd0, 2'd0, 32'd6);
      tick();
    end
    drive_req(1, 4'd0, 2'd0, 32'd0);
    drive_req(0, CMD_SUB, 2'd1, 32'd8);
    tick();
    chk("ar_busy_before", {alu_valid, alu_port}, {1'b1, 2'd1});
    #2;
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("ar_alu_zero", {alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag}, 0);
    chk("ar_out_zero", {|out_data, out_resp, out_tag, err_overflow, err_spurious}, 0);
    tick();
    reset = 1'b1;
    alu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ar_no_stale%0d", k), alu_valid, 0);
    end
    drive_req(0, CMD_ADD, 2'd3, 32'd40);
    tick();
    drive_req(0, 4'd0, 2'd0, 32'd2);
    tick();
    drive_req(0, 4'd0, 2'd0, 32'd0);
    chk("ar_new_issue", {alu_valid, alu_cmd, alu_port, alu_tag, alu_op1, alu_op2},
        {1'b1, CMD_ADD, 2'd0, 2'd3, 32'd40, 32'd2});
    tick();
    drive_res(0, 2'd3, 32'd42, RESP_OK);
    tick();
    res_valid = 1'b0;
    chk("ar_new_result", {od(0), orsp(0), otag(0), err_spurious}, {32'd42, RESP_OK, 2'd3, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
